bus_mem_responder: RTL and testbench

//  Responder end of the ibus/dbus handshake: single-port 64-bit RAM model serving the core's ireq and dreq.

---
 rtl/bus_mem_responder_pkg.sv | 53 +++++
 rtl/bus_mem_responder_if.sv | 24 ++
 rtl/bus_mem_responder_mem_sp64.sv | 27 ++
 rtl/bus_mem_responder.sv | 151 +++++++++++++++
 tb/tb_bus_mem_responder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus_mem_responder_pkg.sv
// Shared types for the ibus/dbus responder: bus request/response structs, FSM state
// and the default memory base address.
package bus_mem_responder_pkg;

  localparam logic [63:0] MEM_BASE_ADDR = 64'h8000_0000;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;
  typedef logic [2:0]  msize_t;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_BUSY_I,
    RSP_BUSY_D,
    RSP_RESP
  } rsp_state_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  // Replace the bytes of old_w selected by be with the matching bytes of new_w.
  function automatic word_t merge_bytes(word_t old_w, word_t new_w, strobe_t be);
    word_t res;
    for (int i = 0; i < 8; i++) begin
      res[i*8 +: 8] = be[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_mem_responder_if.sv
// Bundles the core's instruction and data bus request/response pairs.
interface bus_mem_responder_if;
  import bus_mem_responder_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (
    output ireq,
    output dreq,
    input  iresp,
    input  dresp
  );

  modport slave (
    input  ireq,
    input  dreq,
    output iresp,
    output dresp
  );

endinterface

// File: rtl/bus_mem_responder_mem_sp64.sv
// Single-port 64-bit RAM: synchronous byte-enabled write, combinational read.
module bus_mem_responder_mem_sp64
  import bus_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 65536,
  parameter string       INIT_FILE = "",
  localparam int unsigned AW       = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  strobe_t       be_i,
  input  logic [AW-1:0] addr_i,
  input  word_t         wdata_i,
  output word_t         rdata_o
);

  word_t mem_q [MEM_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= merge_bytes(mem_q[addr_i], wdata_i, be_i);
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bus_mem_responder.sv
// RAM-backed responder for the core's ibus/dbus: fixed dbus priority, programmable
// accept-to-data_ok latency, byte-strobed writes and out-of-range error pulse.
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 65536,
  parameter logic [63:0] BASE_ADDR = MEM_BASE_ADDR,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  bus_mem_responder_if.slave    bus_if,
  output logic                  oob_err_o
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) << 3;
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

  rsp_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  addr_t      addr_q, addr_d;
  strobe_t    strobe_q, strobe_d;
  word_t      wdata_q, wdata_d;

  addr_t         offset;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          done_i, done_d;
  logic          mem_we;
  word_t         rdata;
  ibus_resp_t    iresp;
  dbus_resp_t    dresp;

  // Size is only meaningful to the initiator, which slices the returned word itself.
  logic unused_size;
  assign unused_size = ^bus_if.dreq.size;

  // Range check uses the full latched address before truncating to a word index.
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && (offset < MEM_BYTES);
  assign idx      = offset[AW+2:3];

  // A transaction completes only if the granted initiator is still holding valid.
  assign done_i = (state_q == RSP_BUSY_I) && (cnt_q == 4'd0) && bus_if.ireq.valid;
  assign done_d = (state_q == RSP_BUSY_D) && (cnt_q == 4'd0) && bus_if.dreq.valid;
  assign mem_we = done_d && in_range && (strobe_q != '0);

  bus_mem_responder_mem_sp64 #(
    .MEM_WORDS (MEM_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .be_i    (strobe_q),
    .addr_i  (idx),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= RSP_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      strobe_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      RSP_IDLE: begin
        if (bus_if.dreq.valid) begin
          state_d  = RSP_BUSY_D;
          cnt_d    = CNT_INIT;
          addr_d   = bus_if.dreq.addr;
          strobe_d = bus_if.dreq.strobe;
          wdata_d  = bus_if.dreq.data;
        end else if (bus_if.ireq.valid) begin
          state_d  = RSP_BUSY_I;
          cnt_d    = CNT_INIT;
          addr_d   = bus_if.ireq.addr;
          strobe_d = '0;
          wdata_d  = '0;
        end
      end
      RSP_BUSY_I: begin
        if (!bus_if.ireq.valid) begin
          state_d = RSP_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = RSP_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RSP_BUSY_D: begin
        if (!bus_if.dreq.valid) begin
          state_d = RSP_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = RSP_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RSP_RESP: begin
        state_d = RSP_IDLE;
      end
      default: begin
        state_d = RSP_IDLE;
      end
    endcase
  end

  always_comb begin
    iresp     = '0;
    dresp     = '0;
    oob_err_o = 1'b0;
    if (done_i) begin
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      if (in_range) begin
        iresp.data = addr_q[2] ? rdata[63:32] : rdata[31:0];
      end
    end
    if (done_d) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      if (in_range) begin
        dresp.data = rdata;
      end
    end
    oob_err_o = (done_i || done_d) && !in_range;
  end

  assign bus_if.iresp = iresp;
  assign bus_if.dresp = dresp;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: two instances (latency 2 and 4), scoreboard of
// expected completions checked by a negedge monitor.
module tb_bus_mem_responder;
  import bus_mem_responder_pkg::*;

  localparam int unsigned MW = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_mem_responder_if b2 ();
  bus_mem_responder_if b4 ();
  logic oob2, oob4;

  bus_mem_responder #(.MEM_WORDS(MW), .LATENCY(2)) dut2 (
    .clk_i     (clk),
    .reset_ni  (rst_n),
    .bus_if    (b2),
    .oob_err_o (oob2)
  );

  bus_mem_responder #(.MEM_WORDS(MW), .LATENCY(4)) dut4 (
    .clk_i     (clk),
    .reset_ni  (rst_n),
    .bus_if    (b4),
    .oob_err_o (oob4)
  );

  typedef struct {
    bit          sel;   // 0: dut2, 1: dut4
    bit          isd;
    bit          chkd;
    bit          oob;
    int          cyc;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input bit sel);
    return sel ? 4 : 2;
  endfunction

  function automatic logic dok(input bit sel);
    return sel ? b4.dresp.data_ok : b2.dresp.data_ok;
  endfunction

  function automatic logic iok(input bit sel);
    return sel ? b4.iresp.data_ok : b2.iresp.data_ok;
  endfunction

  task automatic drive(input bit sel, input bit isd, input logic v, input addr_t a,
                       input strobe_t st, input word_t wd);
    dbus_req_t dr;
    ibus_req_t ir;
    dr.valid = v; dr.addr = a; dr.size = 3'd3; dr.strobe = st; dr.data = wd;
    ir.valid = v; ir.addr = a;
    if (isd) begin
      if (sel) b4.dreq = dr; else b2.dreq = dr;
    end else begin
      if (sel) b4.ireq = ir; else b2.ireq = ir;
    end
  endtask

  task automatic expect_done(input bit sel, input bit isd, input int c, input word_t d,
                             input bit chkd, input bit oob);
    exp_t e;
    e.sel = sel; e.isd = isd; e.chkd = chkd; e.oob = oob; e.cyc = c; e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_ok(input bit sel, input bit isd);
    logic got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = isd ? dok(sel) : iok(sel);
    end
    chk64("data_ok_seen", 64'(got), 64'd1);
    if (!got) void'(sb.pop_back());
  endtask

  // Full transaction: request held until data_ok, released the cycle after.
  task automatic issue(input bit sel, input bit isd, input addr_t a, input strobe_t st,
                       input word_t wd, input word_t exp, input bit chkd, input bit oob);
    @(posedge clk); #1;
    drive(sel, isd, 1'b1, a, st, wd);
    expect_done(sel, isd, cyc + lat(sel), exp, chkd, oob);
    wait_ok(sel, isd);
    @(posedge clk); #1;
    drive(sel, isd, 1'b0, '0, '0, '0);
  endtask

  always @(negedge clk) begin
    logic a2, a4, dk, ik, ob;
    logic [63:0] dd, id;
    exp_t e;
    a2 = b2.dresp.data_ok | b2.iresp.data_ok;
    a4 = b4.dresp.data_ok | b4.iresp.data_ok;
    if (a2 || a4) begin
      chk64("sb_nonempty", 64'(sb.size()), (sb.size() == 0) ? 64'd1 : 64'(sb.size()));
      if (sb.size() != 0) begin
        e  = sb.pop_front();
        dk = e.sel ? b4.dresp.data_ok : b2.dresp.data_ok;
        ik = e.sel ? b4.iresp.data_ok : b2.iresp.data_ok;
        ob = e.sel ? oob4 : oob2;
        dd = e.sel ? b4.dresp.data : b2.dresp.data;
        id = e.sel ? {32'b0, b4.iresp.data} : {32'b0, b2.iresp.data};
        chk64("dut_sel", 64'(a4), 64'(e.sel));
        chk64("cycle", 64'(cyc), 64'(e.cyc));
        chk64("dbus_ok", 64'(dk), 64'(e.isd));
        chk64("ibus_ok", 64'(ik), 64'(!e.isd));
        chk64("oob_err", 64'(ob), 64'(e.oob));
        chk64("idle_bus_data", e.isd ? id : dd, 64'd0);
        if (e.chkd) chk64(e.isd ? "dresp_data" : "iresp_data", e.isd ? dd : id, e.data);
      end
    end
  end

  initial begin
    int k;
    int hits;
    b2.ireq = '0; b2.dreq = '0; b4.ireq = '0; b4.dreq = '0;

    // Reset state
    #1;
    chk64("rst_d_ok2", 64'(b2.dresp.data_ok), 64'd0);
    chk64("rst_d_aok2", 64'(b2.dresp.addr_ok), 64'd0);
    chk64("rst_d_data2", b2.dresp.data, 64'd0);
    chk64("rst_i_ok2", 64'(b2.iresp.data_ok), 64'd0);
    chk64("rst_oob2", 64'(oob2), 64'd0);
    chk64("rst_d_ok4", 64'(b4.dresp.data_ok), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Preload dut2
    issue(0, 1, 64'h8000_0000, 8'hFF, 64'h1122_3344_5566_7788, '0, 0, 0);
    issue(0, 1, 64'h8000_0008, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, '0, 0, 0);
    issue(0, 1, 64'h8000_1FF8, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, '0, 0, 0);

    // T1 read latency
    issue(0, 1, 64'h8000_0000, 8'h00, '0, 64'h1122_3344_5566_7788, 1, 0);

    // T2 strobed write and readback
    issue(0, 1, 64'h8000_0008, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, '0, 0, 0);
    issue(0, 1, 64'h8000_0008, 8'h00, '0, 64'hFFFF_FFFF_CCCC_DDDD, 1, 0);
    issue(0, 0, 64'h8000_000C, 8'h00, '0, 64'h0000_0000_FFFF_FFFF, 1, 0);
    issue(0, 0, 64'h8000_0008, 8'h00, '0, 64'h0000_0000_CCCC_DDDD, 1, 0);

    // T3 arbitration: both valid together, dbus first, ibus LATENCY+2 later
    @(posedge clk); #1;
    drive(0, 1, 1'b1, 64'h8000_0000, 8'h00, '0);
    drive(0, 0, 1'b1, 64'h8000_0004, 8'h00, '0);
    k = cyc;
    expect_done(0, 1, k + 2, 64'h1122_3344_5566_7788, 1, 0);
    expect_done(0, 0, k + 6, 64'h0000_0000_1122_3344, 1, 0);
    wait_ok(0, 1);
    @(posedge clk); #1;
    drive(0, 1, 1'b0, '0, '0, '0);
    wait_ok(0, 0);
    @(posedge clk); #1;
    drive(0, 0, 1'b0, '0, '0, '0);

    // T4 out of range on both sides of the window
    issue(0, 1, 64'h7FFF_FFF8, 8'hFF, 64'h0123_0123_0123_0123, '0, 0, 1);
    issue(0, 1, 64'h7FFF_FFF8, 8'h00, '0, 64'd0, 1, 1);
    issue(0, 1, 64'h8000_1FF8, 8'h00, '0, 64'hDEAD_BEEF_0BAD_F00D, 1, 0);
    issue(0, 1, 64'h8000_2000, 8'hFF, 64'h5555_5555_5555_5555, '0, 0, 1);
    issue(0, 0, 64'h8000_2000, 8'h00, '0, 64'd0, 1, 1);
    issue(0, 1, 64'h8000_0000, 8'h00, '0, 64'h1122_3344_5566_7788, 1, 0);

    // T5 abort on dut4 (LATENCY=4)
    issue(1, 1, 64'h8000_0010, 8'hFF, 64'h0123_4567_89AB_CDEF, '0, 0, 0);
    @(posedge clk); #1;
    drive(1, 1, 1'b1, 64'h8000_0010, 8'hFF, 64'hFFFF_0000_FFFF_0000);
    @(posedge clk); #1;
    drive(1, 1, 1'b0, '0, '0, '0);
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (b4.dresp.data_ok) hits++;
    end
    chk64("abort_no_data_ok", 64'(hits), 64'd0);
    issue(1, 0, 64'h8000_0014, 8'h00, '0, 64'h0000_0000_0123_4567, 1, 0);
    issue(1, 1, 64'h8000_0010, 8'h00, '0, 64'h0123_4567_89AB_CDEF, 1, 0);

    // T6 async reset during the would-be data_ok cycle of a write
    issue(0, 1, 64'h8000_0018, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0, '0, 0, 0);
    @(posedge clk); #1;
    drive(0, 1, 1'b1, 64'h8000_0018, 8'hFF, 64'h1234_5678_9ABC_DEF0);
    repeat (2) @(posedge clk);
    #1;
    chk64("pre_reset_d_ok", 64'(b2.dresp.data_ok), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk64("async_rst_d_ok", 64'(b2.dresp.data_ok), 64'd0);
    chk64("async_rst_d_aok", 64'(b2.dresp.addr_ok), 64'd0);
    chk64("async_rst_d_data", b2.dresp.data, 64'd0);
    chk64("async_rst_oob", 64'(oob2), 64'd0);
    drive(0, 1, 1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(0, 1, 64'h8000_0018, 8'h00, '0, 64'hA5A5_5A5A_0F0F_F0F0, 1, 0);

    repeat (4) @(posedge clk);
    chk64("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
